keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clocks each column is driven (dwell), >= 2.
REQ-002 Parameter DEBOUNCE_FRAMES, default 5, meaning consecutive identical full scans needed to accept a press or release, >= 2.
REQ-003 Parameter REPEAT_FRAMES, default 100, meaning frames between auto-repeat pulses; used only under KEYPAD_REPEAT_EN.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 row_in  input  4  keypad rows, active-low; row_in[r]=0 means a key in row r is closed on the driven column.
REQ-007 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-008 onehot  output  16  debounced key, bit index = row*4+col; 16'h0000 = no key.
REQ-009 key_code  output  4  binary index of the set onehot bit; 0 when onehot=0.
REQ-010 key_valid  output  1  one-cycle pulse on each accepted press.

Function
REQ-011 Column counter col 0..3 SHALL advance 0->1->2->3->0 every SCAN_DIV clocks; col_out = ~(4'b0001 << col).
REQ-012 The dwell counter SHALL count 0..SCAN_DIV-1; row_in SHALL be sampled only on the last dwell cycle (count = SCAN_DIV-1), storing ~row_in[r] into frame bit r*4+col.
REQ-013 A frame SHALL complete at the column-3 sample; the completed 16-bit frame is evaluated on that cycle; frame period = 4*SCAN_DIV clocks.
REQ-014 Frame class: ZERO (no bits), SINGLE (exactly one bit), MULTI (two or more bits).
REQ-015 FSM states: IDLE, PRESS_DB, PRESSED, RELEASE_DB; state, counters, and outputs change only at frame evaluation (key_valid clears the following cycle).
REQ-016 IDLE: SINGLE -> PRESS_DB, candidate <= frame, db_cnt <= 1; ZERO or MULTI -> stay.
REQ-017 PRESS_DB: frame = candidate -> db_cnt+1; on reaching DEBOUNCE_FRAMES -> PRESSED, onehot <= candidate, key_code <= its index, key_valid pulses; any other frame -> IDLE, db_cnt <= 0.
REQ-018 PRESSED: ZERO -> RELEASE_DB, db_cnt <= 1; any non-ZERO frame (same key, other key, MULTI) -> stay, outputs unchanged (no rollover).
REQ-019 RELEASE_DB: ZERO -> db_cnt+1; on reaching DEBOUNCE_FRAMES -> IDLE, onehot <= 0, key_code <= 0; non-ZERO -> PRESSED, no new pulse.
REQ-020 Press latency: outputs update on the evaluation cycle of the DEBOUNCE_FRAMES-th matching frame, registered (visible the next clock).
REQ-021 onehot SHALL never hold more than one set bit.
REQ-022 db_cnt width SHALL be sufficient for max(DEBOUNCE_FRAMES, REPEAT_FRAMES) without wrap.

Reset
REQ-023 With rst=1 at a clock edge: col=0, col_out=4'b1110, dwell=0, frame=0, state=IDLE, db_cnt=0, candidate=0, onehot=0, key_code=0, key_valid=0.
REQ-024 Reset mid-operation SHALL discard any debounce progress or held key; a still-held key SHALL be re-debounced from IDLE and produce a new key_valid.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN defined: in PRESSED, a repeat counter counts frames whose value equals onehot; every REPEAT_FRAMES such frames key_valid SHALL pulse again; counter clears on entering PRESSED and in any other state.
REQ-026 KEYPAD_REPEAT_EN undefined: exactly one key_valid per accepted press; repeat logic absent.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 clocks)
REQ-027 rst high 2 cycles, rows 4'hF -> col_out=4'b1110, onehot=0, key_code=0, key_valid=0; col_out steps 1101,1011,0111,1110 every 4 clocks.
REQ-028 Hold row2/col1 closed -> after 3rd frame onehot=16'h0200, key_code=9, key_valid high exactly one cycle.
REQ-029 Key closed on alternate frames for 6 frames -> onehot stays 0, no key_valid.
REQ-030 From REQ-028 state, release 1 frame then re-close -> onehot stays 16'h0200, no pulse; release 3 frames -> onehot=0, key_code=0.
REQ-031 row0/col0 and row0/col1 closed together from IDLE -> onehot 0, no pulse; release col1 only -> 16'h0001 accepted after 3 frames.
REQ-032 rst pulse while 16'h0200 held -> onehot=0 next cycle; new key_valid 3 frames later; with KEYPAD_REPEAT_EN, REPEAT_FRAMES=2 -> further pulses every 2 frames while held.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scanning, frame-level debounce, one-hot/binary key output.
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat key_valid pulses while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5,
    parameter int REPEAT_FRAMES   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] onehot,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    localparam int DW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_MAX = (DEBOUNCE_FRAMES > REPEAT_FRAMES) ? DEBOUNCE_FRAMES : REPEAT_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    logic [DW-1:0] dwell_reg;
    logic [1:0]    col_reg;
    logic [15:0]   frame_reg;
    logic [15:0]   frame_now;
    logic          sample;
    logic          frame_eval;
    logic          frame_zero;
    logic          frame_single;

    state_t        state_reg, state_next;
    logic [CW-1:0] db_cnt_reg, db_cnt_next;
    logic [CW-1:0] db_inc;
    logic [15:0]   candidate_reg, candidate_next;
    logic [15:0]   onehot_reg, onehot_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic          key_valid_reg, key_valid_next;

    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

    assign sample     = (dwell_reg == DW'(SCAN_DIV - 1));
    assign frame_eval = sample && (col_reg == 2'd3);
    assign col_out    = ~(4'b0001 << col_reg);

    // The column being sampled is merged in combinationally so the full frame is ready on the column-3 sample.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_frame_bit
            assign frame_now[gi] = (sample && (col_reg == 2'(gi % 4))) ? ~row_in[gi / 4] : frame_reg[gi];
        end
    endgenerate

    assign frame_zero   = (frame_now == 16'h0000);
    assign frame_single = !frame_zero && ((frame_now & (frame_now - 16'd1)) == 16'h0000);
    assign db_inc       = db_cnt_reg + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg <= '0;
            col_reg   <= 2'd0;
            frame_reg <= 16'h0000;
        end else begin
            frame_reg <= frame_now;
            if (sample) begin
                dwell_reg <= '0;
                col_reg   <= col_reg + 2'd1;
            end else begin
                dwell_reg <= dwell_reg + DW'(1);
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [CW-1:0] rep_cnt_reg, rep_cnt_next;
    logic [CW-1:0] rep_inc;
    assign rep_inc = rep_cnt_reg + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) rep_cnt_reg <= '0;
        else     rep_cnt_reg <= rep_cnt_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            db_cnt_reg    <= '0;
            candidate_reg <= 16'h0000;
            onehot_reg    <= 16'h0000;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            candidate_reg <= candidate_next;
            onehot_reg    <= onehot_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        db_cnt_next    = db_cnt_reg;
        candidate_next = candidate_reg;
        onehot_next    = onehot_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_next   = (state_reg == PRESSED) ? rep_cnt_reg : '0;
`endif
        if (frame_eval) begin
            unique case (state_reg)
                IDLE: begin
                    if (frame_single) begin
                        state_next     = PRESS_DB;
                        candidate_next = frame_now;
                        db_cnt_next    = CW'(1);
                    end
                end
                PRESS_DB: begin
                    if (frame_now == candidate_reg) begin
                        if (db_inc == CW'(DEBOUNCE_FRAMES)) begin
                            state_next     = PRESSED;
                            db_cnt_next    = '0;
                            onehot_next    = candidate_reg;
                            key_code_next  = onehot_index(candidate_reg);
                            key_valid_next = 1'b1;
                        end else begin
                            db_cnt_next = db_inc;
                        end
                    end else begin
                        state_next  = IDLE;
                        db_cnt_next = '0;
                    end
                end
                PRESSED: begin
                    if (frame_zero) begin
                        state_next  = RELEASE_DB;
                        db_cnt_next = CW'(1);
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_next = '0;
                    end else if (frame_now == onehot_reg) begin
                        if (rep_inc == CW'(REPEAT_FRAMES)) begin
                            rep_cnt_next   = '0;
                            key_valid_next = 1'b1;
                        end else begin
                            rep_cnt_next = rep_inc;
                        end
`endif
                    end
                end
                RELEASE_DB: begin
                    if (frame_zero) begin
                        if (db_inc == CW'(DEBOUNCE_FRAMES)) begin
                            state_next    = IDLE;
                            db_cnt_next   = '0;
                            onehot_next   = 16'h0000;
                            key_code_next = 4'd0;
                        end else begin
                            db_cnt_next = db_inc;
                        end
                    end else begin
                        // Bounce during release: resume the held key without a new pulse.
                        state_next  = PRESSED;
                        db_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign onehot    = onehot_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes keys per frame; a frame-level debounce model predicts outputs.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int REP      = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    // Reference model state, in terms of frames seen
    logic [15:0] m_onehot = 16'h0000;
    logic [15:0] m_cand   = 16'h0000;
    int          m_pcnt = 0, m_rcnt = 0, m_rep = 0;
    bit          m_pulse = 1'b0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(REP)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .onehot(onehot), .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] index_of(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_onehot = 16'h0000; m_cand = 16'h0000;
        m_pcnt = 0; m_rcnt = 0; m_rep = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] f);
        m_pulse = 1'b0;
        if (m_onehot == 16'h0000) begin
            if (m_pcnt > 0) begin
                if (f == m_cand) begin
                    m_pcnt++;
                    if (m_pcnt == DB) begin
                        m_onehot = f; m_pulse = 1'b1; m_pcnt = 0; m_rcnt = 0; m_rep = 0;
                    end
                end else begin
                    m_pcnt = 0;
                end
            end else if ($countones(f) == 1) begin
                m_cand = f; m_pcnt = 1;
            end
        end else begin
            if (f == 16'h0000) begin
                m_rcnt++; m_rep = 0;
                if (m_rcnt == DB) begin m_onehot = 16'h0000; m_rcnt = 0; end
            end else if (m_rcnt > 0) begin
                m_rcnt = 0; m_rep = 0;
            end else if (REP_ON && f == m_onehot) begin
                m_rep++;
                if (m_rep == REP) begin m_pulse = 1'b1; m_rep = 0; end
            end
        end
    endtask

    task automatic reset_dut(input int cycles);
        logic [3:0] exp_col;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        exp_col = 4'b1110;
        check("rst_col_out", 32'(col_out), 32'(exp_col));
        check("rst_onehot", 32'(onehot), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    // One full frame with a fixed key set; keys change only just after a frame evaluation edge.
    task automatic run_frame(input logic [15:0] k);
        logic [3:0] exp_col;
        keys = k;
        for (int n = 1; n <= 4 * SCAN_DIV; n++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((n / SCAN_DIV) % 4));
            check("col_out", 32'(col_out), 32'(exp_col));
            if (n < 4 * SCAN_DIV) check("key_valid_between", 32'(key_valid), 32'h0);
        end
        model_step(k);
        frame_no++;
        check("key_valid", 32'(key_valid), 32'(m_pulse));
        check("onehot", 32'(onehot), 32'(m_onehot));
        check("key_code", 32'(key_code), 32'(index_of(m_onehot)));
        check("onehot_single", 32'($countones(onehot) <= 1), 32'h1);
        $display("frame %0d keys=%h onehot=%h key_code=%0d key_valid=%0b",
                 frame_no, k, onehot, key_code, key_valid);
    endtask

    initial begin
        logic [15:0] last_key;
        logic [15:0] f;
        int          a, b, sel;

        reset_dut(2);

        // Hold row2/col1 for three frames, then release bounce and real release
        repeat (3) run_frame(16'h0200);
        run_frame(16'h0000);
        run_frame(16'h0200);
        repeat (3) run_frame(16'h0000);

        // Alternating closure never debounces
        repeat (3) begin
            run_frame(16'h0200);
            run_frame(16'h0000);
        end

        // Two keys together are ignored; single remaining key is accepted
        repeat (3) run_frame(16'h0003);
        repeat (3) run_frame(16'h0001);
        repeat (3) run_frame(16'h0000);

        // Reset mid-frame while a key is held; it must be re-debounced
        repeat (5) run_frame(16'h0200);
        repeat (5) @(posedge clk);
        reset_dut(1);
        repeat (7) run_frame(16'h0200);
        repeat (3) run_frame(16'h0000);

        // Randomized key activity
        last_key = 16'h0020;
        for (int i = 0; i < 50; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                f = last_key;
            end else if (sel <= 5) begin
                f = 16'h0000;
            end else if (sel <= 7) begin
                f = 16'h0001 << $urandom_range(0, 15);
                last_key = f;
            end else if (sel == 8) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                f = (16'h0001 << a) | (16'h0001 << b);
            end else begin
                f = 16'($urandom());
            end
            run_frame(f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
